// File: rtl/risk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risk_pkg
// Description : Shared types, default widths and helpers for the pre-trade
//               risk check sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package risk_pkg;

    // Default order-line index width (memory depth is 2**c_def_id_w)
    localparam int c_def_id_w  = 8;
    // Default amount / limit width in pounds
    localparam int c_def_amt_w = 32;
    // Working width of the saturating adder; amount widths up to this are supported
    localparam int c_sat_w     = 64;

    // Operation codes presented on req_op
    typedef enum logic [1:0] {
        OP_ORDER  = 2'd0,
        OP_REDUCE = 2'd1,
        OP_SETMAX = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    // Sequencer states
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Unsigned add that clamps to the largest value representable in 'width'
    // bits. Operands are carried at c_sat_w bits so any field width fits.
    function automatic logic [c_sat_w-1:0] sat_add(
        input logic [c_sat_w-1:0] a,
        input logic [c_sat_w-1:0] b,
        input int unsigned        width
    );
        logic [c_sat_w:0] sum;
        logic [c_sat_w:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{c_sat_w{1'b0}}, 1'b1} << width) - {{c_sat_w{1'b0}}, 1'b1};
        if (sum > lim) begin
            return lim[c_sat_w-1:0];
        end
        return sum[c_sat_w-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/risk_eval.sv
`default_nettype none
// ============================================================================
// Module      : risk_eval
// Description : Combinational evaluation of one risk operation against the
//               line record: pass/fail, updated record, and whether the
//               record actually changed (and so needs writing back).
// Revision    : 1.0 - initial release
// ============================================================================
module risk_eval
    import risk_pkg::*;
#(
    parameter int AMT_W = c_def_amt_w
) (
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] max,
    input  logic [AMT_W-1:0] acc,
    input  logic [AMT_W-1:0] red,
    input  logic [AMT_W-1:0] amount,
    output logic             fail,
    output logic             wr_needed,
    output logic [AMT_W-1:0] new_max,
    output logic [AMT_W-1:0] new_acc,
    output logic [AMT_W-1:0] new_red
);

    localparam int unsigned c_amt_w_u = AMT_W;

    // Projected exposure and limit, two extra bits so acc+amount cannot
    // overflow and a large reduction shows up as a negative value.
    logic signed [AMT_W+1:0] w_future;
    logic signed [AMT_W+1:0] w_max_ext;
    logic        [AMT_W-1:0] w_acc_sat;
    logic        [AMT_W-1:0] w_red_sat;

    assign w_future  = $signed({2'b00, acc}) + $signed({2'b00, amount})
                     - $signed({2'b00, red});
    assign w_max_ext = $signed({2'b00, max});
    assign w_acc_sat = AMT_W'(sat_add(c_sat_w'(acc), c_sat_w'(amount), c_amt_w_u));
    assign w_red_sat = AMT_W'(sat_add(c_sat_w'(red), c_sat_w'(amount), c_amt_w_u));

    // Apply the operation; a failed or reserved op leaves the record as read
    always_comb begin
        fail    = 1'b0;
        new_max = max;
        new_acc = acc;
        new_red = red;
        case (op)
            OP_ORDER: begin
                // Negative future is always below the (unsigned) max, so it passes
                fail = (w_future > w_max_ext);
                if (!fail) begin
                    new_acc = w_acc_sat;
                end
            end
            OP_REDUCE: begin
                new_red = w_red_sat;
            end
            OP_SETMAX: begin
                new_max = amount;
            end
            default: begin
                fail = 1'b1;
            end
        endcase
        // Only touch the RAM when a field really changes
        wr_needed = !fail && ({new_max, new_acc, new_red} != {max, acc, red});
    end

endmodule
`default_nettype wire

// File: rtl/risk_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : risk_check_ctrl
// Description : Per-order-line pre-trade risk check sequencer. Clears the
//               limit RAM after reset, then runs one read-evaluate-write-
//               respond operation at a time against the single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module risk_check_ctrl
    import risk_pkg::*;
#(
    parameter int ID_W  = c_def_id_w,
    parameter int AMT_W = c_def_amt_w
) (
    input  logic             clk,
    input  logic             rst,
    // Request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [ID_W-1:0]  req_id,
    input  logic [AMT_W-1:0] req_amount,
    // Limit RAM read port (data valid one cycle after mem_rd_en)
    output logic             mem_rd_en,
    output logic [ID_W-1:0]  mem_rd_addr,
    input  logic [AMT_W-1:0] mem_rd_max,
    input  logic [AMT_W-1:0] mem_rd_acc,
    input  logic [AMT_W-1:0] mem_rd_red,
    // Limit RAM write port
    output logic             mem_wr_en,
    output logic [ID_W-1:0]  mem_wr_addr,
    output logic [AMT_W-1:0] mem_wr_max,
    output logic [AMT_W-1:0] mem_wr_acc,
    output logic [AMT_W-1:0] mem_wr_red,
    // Response
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [ID_W-1:0]  resp_id,
    output logic             resp_fail,
    // Status
    output logic             init_done
);

    localparam logic [ID_W-1:0] c_last_addr = {ID_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;

    logic [ID_W-1:0]  r_init_addr;
    logic             r_init_done;

    op_t              r_op;
    logic [ID_W-1:0]  r_id;
    logic [AMT_W-1:0] r_amount;

    logic             r_fail;
    logic             r_wr_needed;
    logic [AMT_W-1:0] r_new_max;
    logic [AMT_W-1:0] r_new_acc;
    logic [AMT_W-1:0] r_new_red;

    logic             w_eval_fail;
    logic             w_eval_wr;
    logic [AMT_W-1:0] w_eval_max;
    logic [AMT_W-1:0] w_eval_acc;
    logic [AMT_W-1:0] w_eval_red;

    logic             w_req_ready;
    logic             w_rd_en;
    logic             w_wr_en;
    logic             w_resp_valid;
    logic             w_in_init;

    // ------------------------------------------------------------------------
    // Evaluation of the record returned by the RAM during CALC
    // ------------------------------------------------------------------------
    risk_eval #(
        .AMT_W (AMT_W)
    ) u_eval (
        .op        (r_op),
        .max       (mem_rd_max),
        .acc       (mem_rd_acc),
        .red       (mem_rd_red),
        .amount    (r_amount),
        .fail      (w_eval_fail),
        .wr_needed (w_eval_wr),
        .new_max   (w_eval_max),
        .new_acc   (w_eval_acc),
        .new_red   (w_eval_red)
    );

    // State register; reset always returns to the RAM clear sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore strobes, defaults first
    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_INIT: begin
                w_wr_en = 1'b1;
                if (r_init_addr == c_last_addr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd_en     = 1'b1;
                w_state_nxt = S_CALC;
            end
            S_CALC: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // The cycle elapses even when the record is unchanged
                w_wr_en     = r_wr_needed;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // Clear-sweep address; wraps back to 0 on leaving INIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_addr <= '0;
        end else if (r_state == S_INIT) begin
            r_init_addr <= r_init_addr + ID_W'(1);
        end
    end

    // Sticky RAM-cleared flag, set as the last clear write is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else if ((r_state == S_INIT) && (r_init_addr == c_last_addr)) begin
            r_init_done <= 1'b1;
        end
    end

    // Capture the request on acceptance in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_ORDER;
            r_id     <= '0;
            r_amount <= '0;
        end else if ((r_state == S_IDLE) && req_valid) begin
            r_op     <= op_t'(req_op);
            r_id     <= req_id;
            r_amount <= req_amount;
        end
    end

    // Register the evaluation while the read data is valid in CALC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail      <= 1'b0;
            r_wr_needed <= 1'b0;
            r_new_max   <= '0;
            r_new_acc   <= '0;
            r_new_red   <= '0;
        end else if (r_state == S_CALC) begin
            r_fail      <= w_eval_fail;
            r_wr_needed <= w_eval_wr;
            r_new_max   <= w_eval_max;
            r_new_acc   <= w_eval_acc;
            r_new_red   <= w_eval_red;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Strobes are held low while rst is high so that nothing is
    // issued in any cycle where reset is asserted, including the one where it
    // first arrives mid-operation.
    // ------------------------------------------------------------------------
    assign w_in_init   = (r_state == S_INIT);

    assign req_ready   = w_req_ready  & ~rst;
    assign mem_rd_en   = w_rd_en      & ~rst;
    assign mem_wr_en   = w_wr_en      & ~rst;
    assign resp_valid  = w_resp_valid & ~rst;
    assign init_done   = r_init_done  & ~rst;

    assign mem_rd_addr = r_id;
    assign mem_wr_addr = w_in_init ? r_init_addr : r_id;
    assign mem_wr_max  = w_in_init ? '0 : r_new_max;
    assign mem_wr_acc  = w_in_init ? '0 : r_new_acc;
    assign mem_wr_red  = w_in_init ? '0 : r_new_red;

    assign resp_id     = r_id;
    assign resp_fail   = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_risk_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_risk_check_ctrl
// Description : Self-checking bench for risk_check_ctrl with a behavioural
//               limit RAM and an independent reference record model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risk_check_ctrl;

    localparam int ID_W  = 4;
    localparam int AMT_W = 32;
    localparam int DEPTH = 16;
    localparam longint c_lim = 64'd4294967295;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [ID_W-1:0]  req_id = '0;
    logic [AMT_W-1:0] req_amount = '0;
    logic             mem_rd_en;
    logic [ID_W-1:0]  mem_rd_addr;
    logic [AMT_W-1:0] mem_rd_max = '0;
    logic [AMT_W-1:0] mem_rd_acc = '0;
    logic [AMT_W-1:0] mem_rd_red = '0;
    logic             mem_wr_en;
    logic [ID_W-1:0]  mem_wr_addr;
    logic [AMT_W-1:0] mem_wr_max;
    logic [AMT_W-1:0] mem_wr_acc;
    logic [AMT_W-1:0] mem_wr_red;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [ID_W-1:0]  resp_id;
    logic             resp_fail;
    logic             init_done;

    logic             scramble = 1'b1;

    logic [31:0] ram_max [DEPTH];
    logic [31:0] ram_acc [DEPTH];
    logic [31:0] ram_red [DEPTH];

    longint ref_max [DEPTH];
    longint ref_acc [DEPTH];
    longint ref_red [DEPTH];

    int n_vec  = 0;
    int n_fail = 0;

    risk_check_ctrl #(
        .ID_W  (ID_W),
        .AMT_W (AMT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_id      (req_id),
        .req_amount  (req_amount),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_max  (mem_rd_max),
        .mem_rd_acc  (mem_rd_acc),
        .mem_rd_red  (mem_rd_red),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_max  (mem_wr_max),
        .mem_wr_acc  (mem_wr_acc),
        .mem_wr_red  (mem_wr_red),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_fail   (resp_fail),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port limit RAM: one-cycle read latency
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_max[i] <= 32'hDEAD_0000 | 32'(i);
                ram_acc[i] <= 32'hBEEF_0000 | 32'(i);
                ram_red[i] <= 32'hCAFE_0000 | 32'(i);
            end
        end else begin
            if (mem_rd_en) begin
                mem_rd_max <= ram_max[mem_rd_addr];
                mem_rd_acc <= ram_acc[mem_rd_addr];
                mem_rd_red <= ram_red[mem_rd_addr];
            end
            if (mem_wr_en) begin
                ram_max[mem_wr_addr] <= mem_wr_max;
                ram_acc[mem_wr_addr] <= mem_wr_acc;
                ram_red[mem_wr_addr] <= mem_wr_red;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rules for one operation on a record
    function automatic void ref_eval(
        input  logic [1:0] op,
        input  longint     mx,
        input  longint     ac,
        input  longint     rd,
        input  longint     amt,
        output logic       fail,
        output longint     nmx,
        output longint     nac,
        output longint     nrd
    );
        fail = 1'b0;
        nmx  = mx;
        nac  = ac;
        nrd  = rd;
        case (op)
            2'd0: begin
                if (ac + amt - rd > mx) fail = 1'b1;
                else nac = (ac + amt > c_lim) ? c_lim : ac + amt;
            end
            2'd1: nrd = (rd + amt > c_lim) ? c_lim : rd + amt;
            2'd2: nmx = amt;
            default: fail = 1'b1;
        endcase
    endfunction

    task automatic check_ram(input logic [ID_W-1:0] id);
        logic [31:0] em, ea, er;
        em = 32'(ref_max[id]);
        ea = 32'(ref_acc[id]);
        er = 32'(ref_red[id]);
        check("ram_record", {ram_max[id], ram_acc[id], ram_red[id]}, {em, ea, er});
    endtask

    task automatic reset_and_init();
        int nz;
        rst       = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {req_ready, mem_rd_en, mem_wr_en, resp_valid, init_done}, 0);
        check("rst_data", {resp_fail, resp_id, mem_rd_addr, mem_wr_addr,
                           mem_wr_max, mem_wr_acc, mem_wr_red}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        scramble = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("init_write", {mem_wr_en, mem_rd_en, req_ready, init_done, mem_wr_addr,
                                 mem_wr_max, mem_wr_acc, mem_wr_red},
                  {4'b1000, 4'(i), 96'h0});
        end
        @(negedge clk);
        check("init_done", {req_ready, init_done, mem_wr_en}, 3'b110);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({ram_max[i], ram_acc[i], ram_red[i]} != 96'h0) nz++;
            ref_max[i] = 0;
            ref_acc[i] = 0;
            ref_red[i] = 0;
        end
        check("ram_cleared", 32'(nz), 0);
    endtask

    task automatic wait_ready();
        int b = 0;
        while (req_ready !== 1'b1 && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    // One complete operation, optionally stalling the response 'hold' cycles
    task automatic run_op(input logic [1:0] op, input logic [ID_W-1:0] id,
                          input logic [31:0] amt, input int hold);
        logic   ef, ew;
        longint nmx, nac, nrd;
        logic [31:0] xm, xa, xr;
        ref_eval(op, ref_max[id], ref_acc[id], ref_red[id], longint'(amt), ef, nmx, nac, nrd);
        ew = !ef && (nmx != ref_max[id] || nac != ref_acc[id] || nrd != ref_red[id]);
        xm = 32'(nmx);
        xa = 32'(nac);
        xr = 32'(nrd);
        wait_ready();
        req_valid  = 1'b1;
        req_op     = op;
        req_id     = id;
        req_amount = amt;
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("read", {mem_rd_en, mem_wr_en, req_ready, mem_rd_addr}, {3'b100, id});
        @(negedge clk);
        check("calc", {mem_rd_en, mem_wr_en, resp_valid, req_ready}, 0);
        @(negedge clk);
        if (ew) check("write", {mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_max, mem_wr_acc, mem_wr_red},
                      {2'b10, id, xm, xa, xr});
        else    check("no_write", {mem_wr_en, mem_rd_en}, 0);
        @(negedge clk);
        check("resp", {resp_valid, req_ready, resp_id, resp_fail}, {2'b10, id, ef});
        for (int k = 0; k < hold; k++) begin
            req_valid  = 1'b1;
            req_op     = 2'($urandom_range(0, 3));
            req_id     = id ^ 4'h1;
            req_amount = $urandom;
            @(negedge clk);
            check("resp_hold", {resp_valid, req_ready, mem_rd_en, mem_wr_en, resp_id, resp_fail},
                  {4'b1000, id, ef});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("back_to_idle", {resp_valid, req_ready, mem_rd_en, mem_wr_en}, 4'b0100);
        if (ew) begin
            ref_max[id] = nmx;
            ref_acc[id] = nac;
            ref_red[id] = nrd;
        end
        check_ram(id);
    endtask

    // Operation aborted by reset while the DUT is in CALC
    task automatic abort_op(input logic [1:0] op, input logic [ID_W-1:0] id, input logic [31:0] amt);
        wait_ready();
        req_valid  = 1'b1;
        req_op     = op;
        req_id     = id;
        req_amount = amt;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_read", mem_rd_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_quiet", {mem_wr_en, resp_valid, req_ready, init_done}, 0);
        check_ram(id);
    endtask

    initial begin
        logic [31:0] amt;
        reset_and_init();

        // Limit set, pass, breach, reduction then pass again
        run_op(2'd2, 4'd3, 32'd1000, 0);
        run_op(2'd0, 4'd3, 32'd600, 0);
        run_op(2'd0, 4'd3, 32'd500, 0);
        run_op(2'd1, 4'd3, 32'd200, 0);
        run_op(2'd0, 4'd3, 32'd500, 0);

        // Build acc=2^32-10, max=red=2^32-1, then saturate acc
        run_op(2'd2, 4'd5, 32'hFFFF_FFFF, 0);
        run_op(2'd1, 4'd5, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 4'd5, 32'hFFFF_FFF6, 0);
        run_op(2'd0, 4'd5, 32'd100, 0);

        // Fresh line rejects, zero-amount/unchanged records and reserved op
        run_op(2'd0, 4'd7, 32'd1, 0);
        run_op(2'd0, 4'd7, 32'd0, 0);
        run_op(2'd3, 4'd3, 32'd50, 0);
        run_op(2'd2, 4'd3, 32'd1000, 0);

        // Response back-pressure with a competing request
        run_op(2'd1, 4'd3, 32'd5, 10);

        // Reset in CALC: nothing written, sweep restarts at 0
        abort_op(2'd1, 4'd3, 32'd50);
        reset_and_init();

        // Randomised operations on a few colliding lines
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       amt = 32'($urandom_range(0, 2000));
                1:       amt = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
                2:       amt = 32'd0;
                default: amt = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), amt,
                   ($urandom_range(0, 7) == 0) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
